seq_engine_sched: RTL

- Round-robin scheduler that shares one serial sequence-detector engine (1-bit `x` in, 1-bit `out`) between N_REQ requesters.
- Each granted requester submits a DATA_W-bit frame. The scheduler clears the engine, shifts the frame in MSB-first, and counts the cycles in which the engine output is high.
- It then returns the count and final output to the winner with a one-cycle done pulse.
- Sits between the requesting control blocks and the single detector instance.

---
 rtl/seq_sched_pkg.sv | 13 +
 rtl/seq_engine_sched_rr_pick.sv | 27 ++
 rtl/seq_engine_sched.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/seq_sched_pkg.sv
// Shared types and defaults for the round-robin sequence-engine scheduler.
package seq_sched_pkg;
    localparam int DEF_N_REQ  = 4;
    localparam int DEF_DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_SHIFT,
        ST_RESP,
        ST_DONE
    } state_t;
endpackage

// File: rtl/seq_engine_sched_rr_pick.sv
// Combinational round-robin picker: first requester at or above ptr, with wrap.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  idx,
    output logic             any
);
    always_comb begin
        int j;
        j   = 0;
        any = 1'b0;
        idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            j = int'(ptr) + k;
            if (j >= N_REQ) j = j - N_REQ;
            if (!any && req[j]) begin
                any = 1'b1;
                idx = ID_W'(j);
            end
        end
        gnt = any ? (N_REQ'(1) << idx) : '0;
    end
endmodule

// File: rtl/seq_engine_sched.sv
// Shares one serial sequence-detector engine between N_REQ requesters: clear,
// shift a frame in MSB-first, count high outputs, report to the winner.
module seq_engine_sched
    import seq_sched_pkg::*;
#(
    parameter int N_REQ  = DEF_N_REQ,
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = $clog2(DATA_W + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   data_in,
    output logic [N_REQ-1:0]          gnt,
    output logic                      eng_rst,
    output logic                      eng_x,
    input  logic                      eng_out,
    output logic                      busy,
    output logic                      done,
    output logic [$clog2(N_REQ)-1:0]  done_id,
    output logic [CNT_W-1:0]          result_cnt,
    output logic                      result_last
);
    localparam int ID_W  = $clog2(N_REQ);
    localparam int BIT_W = $clog2(DATA_W);

    state_t              state_q, state_d;
    logic [N_REQ-1:0]    gnt_q, gnt_d;
    logic                eng_rst_q, eng_rst_d;
    logic [DATA_W-1:0]   shreg_q, shreg_d;
    logic [BIT_W-1:0]    bitcnt_q, bitcnt_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                last_q, last_d;
    logic [ID_W-1:0]     winner_q, winner_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;

    logic [DATA_W-1:0]   frame [N_REQ];
    logic [N_REQ-1:0]    winner_oh, pick_req, pick_gnt;
    logic [ID_W-1:0]     win_inc, pick_ptr, pick_idx;
    logic                pick_any, in_done, launch;

    for (genvar g = 0; g < N_REQ; g++) begin : g_frame
        assign frame[g] = data_in[g*DATA_W +: DATA_W];
    end

    // In DONE the winner's req is still falling, so it is masked and the
    // search starts just past the winner (the pointer value being written).
    assign in_done   = (state_q == ST_DONE);
    assign winner_oh = N_REQ'(1) << winner_q;
    assign win_inc   = (winner_q == ID_W'(N_REQ - 1)) ? '0 : winner_q + 1'b1;
    assign pick_req  = in_done ? (req & ~winner_oh) : req;
    assign pick_ptr  = in_done ? win_inc : ptr_q;
    assign launch    = pick_any && (state_q == ST_IDLE || in_done);

    rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
        .req (pick_req),
        .ptr (pick_ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        eng_rst_d = 1'b0;
        shreg_d   = shreg_q;
        bitcnt_d  = bitcnt_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        winner_d  = winner_q;
        ptr_d     = ptr_q;
        case (state_q)
            ST_IDLE: ;
            ST_CLR: begin
                bitcnt_d = '0;
                cnt_d    = '0;
                state_d  = ST_SHIFT;
            end
            ST_SHIFT: begin
                shreg_d  = {shreg_q[DATA_W-2:0], 1'b0};
                bitcnt_d = bitcnt_q + 1'b1;
                // eng_out in the first SHIFT cycle still reflects the cleared engine
                if (bitcnt_q != '0) cnt_d = cnt_q + CNT_W'(eng_out);
                if (bitcnt_q == BIT_W'(DATA_W - 1)) state_d = ST_RESP;
            end
            ST_RESP: begin
                cnt_d   = cnt_q + CNT_W'(eng_out);
                last_d  = eng_out;
                gnt_d   = '0;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                ptr_d   = win_inc;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (launch) begin
            state_d   = ST_CLR;
            gnt_d     = pick_gnt;
            winner_d  = pick_idx;
            shreg_d   = frame[pick_idx];
            eng_rst_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            gnt_q     <= '0;
            eng_rst_q <= 1'b1;
            shreg_q   <= '0;
            bitcnt_q  <= '0;
            cnt_q     <= '0;
            last_q    <= 1'b0;
            winner_q  <= '0;
            ptr_q     <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            eng_rst_q <= eng_rst_d;
            shreg_q   <= shreg_d;
            bitcnt_q  <= bitcnt_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            winner_q  <= winner_d;
            ptr_q     <= ptr_d;
        end
    end

    assign gnt         = gnt_q;
    assign eng_rst     = eng_rst_q;
    assign eng_x       = (state_q == ST_SHIFT) & shreg_q[DATA_W-1];
    assign busy        = (state_q != ST_IDLE);
    assign done        = in_done;
    assign done_id     = winner_q;
    assign result_cnt  = cnt_q;
    assign result_last = last_q;
endmodule
